// File: rtl/bus_mux_pkg.sv
// Shared constants and helpers for the N-channel bus source multiplexer.
package bus_mux_pkg;
  localparam logic MODE_DIRECT   = 1'b0;
  localparam logic MODE_RR       = 1'b1;
  localparam int   DEF_WORD_SIZE = 16;
  localparam int   DEF_NUM_CH    = 4;
  localparam int   DEF_SEL_SIZE  = 2;

  // Wraps at num_ch, not at the select width, so odd channel counts rotate correctly.
  function automatic int rr_next(input int idx, input int num_ch);
    return (idx + 1 >= num_ch) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter_nch.sv
// Combinational round-robin picker: first valid channel at or after rr_ptr, wrapping at NUM_CH.
module rr_arbiter_nch import bus_mux_pkg::*; #(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SEL_SIZE = DEF_SEL_SIZE
) (
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [SEL_SIZE-1:0] rr_ptr,
  output logic                grant_valid,
  output logic [SEL_SIZE-1:0] grant_idx
);
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Scan farthest offset first so the closest valid channel overwrites last and wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (in_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_SIZE'(idx);
      end
    end
  end
endmodule

// File: rtl/bus_mux_nch.sv
// Registered N-channel bus source mux with direct/round-robin grant and output backpressure.
// Optional even-parity output enabled by defining BUS_MUX_PARITY_EN.
module bus_mux_nch import bus_mux_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SEL_SIZE  = DEF_SEL_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic                        mode,
  input  logic [SEL_SIZE-1:0]         sel,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic [SEL_SIZE-1:0]         out_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err
`ifdef BUS_MUX_PARITY_EN
  ,output logic                       out_parity
`endif
);
  logic                 slot_free, dir_vld, sel_ok, rr_gvld, grant_valid, xfer;
  logic [SEL_SIZE-1:0]  rr_gidx, grant_idx;
  logic [WORD_SIZE-1:0] grant_word;

  logic [WORD_SIZE-1:0] out_data_d, out_data_q;
  logic [SEL_SIZE-1:0]  out_ch_d, out_ch_q, rr_ptr_d, rr_ptr_q;
  logic                 out_valid_d, out_valid_q, sel_err_d, sel_err_q;

  rr_arbiter_nch #(.NUM_CH(NUM_CH), .SEL_SIZE(SEL_SIZE)) u_arb (
    .in_valid    (in_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (rr_gvld),
    .grant_idx   (rr_gidx)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel_ok    = int'(sel) < NUM_CH;
    // Loop-based lookup keeps an out-of-range sel from indexing past in_valid.
    dir_vld   = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel == SEL_SIZE'(k)) dir_vld = in_valid[k];

    if (mode == MODE_RR) begin
      grant_valid = rr_gvld;
      grant_idx   = rr_gidx;
    end else begin
      grant_valid = dir_vld;
      grant_idx   = sel;
    end
    xfer = rst && grant_valid && slot_free;

    grant_word = '0;
    in_ready   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_SIZE'(k)) begin
        grant_word  = in_data[k*WORD_SIZE +: WORD_SIZE];
        in_ready[k] = xfer;
      end
    end

    out_data_d  = xfer ? grant_word : out_data_q;
    out_ch_d    = xfer ? grant_idx  : out_ch_q;
    out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    rr_ptr_d    = (xfer && mode == MODE_RR) ? SEL_SIZE'(rr_next(int'(grant_idx), NUM_CH)) : rr_ptr_q;
    sel_err_d   = (mode == MODE_DIRECT) && !sel_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

`ifdef BUS_MUX_PARITY_EN
  logic out_parity_d, out_parity_q;
  assign out_parity_d = xfer ? ^grant_word : out_parity_q;
  always_ff @(posedge clk) begin
    if (!rst) out_parity_q <= 1'b0;
    else      out_parity_q <= out_parity_d;
  end
  assign out_parity = out_parity_q;
`endif

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
endmodule
